pe_result_drain: RTL
====================

Name: pe_result_drain

Overview:
Downstream stage of the systolic PE array. Captures each PE's accumulated result on that PE's result-valid pulse into a local result bank. Once all ROWS*COLS results are held, it serialises them in row-major order (index = col + row*COLS, the array's own index order) onto a single valid/ready stream toward the output buffer or host interface. It asserts busy while draining so the array controller withholds the next fire.

Parameters:
ROWS, 8, PE array rows; must match the array instance.
COLS, 8, PE array columns; must match the array instance.
OUTWIDTH, 32, result width per PE.
IDXW, $clog2(ROWS*COLS), width of the result index output.

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset, sampled on rising clk.
in_r  input  OUTWIDTH x [0:ROWS*COLS-1]  per-PE result, unpacked array indexed col + row*COLS.
in_rvalid  input  1 x [0:ROWS*COLS-1]  per-PE result-valid pulse, same indexing.
out_data  output  OUTWIDTH  current result on the stream.
out_idx  output  IDXW  PE index of out_data.
out_valid  output  1  stream valid.
out_last  output  1  high with the final element (idx ROWS*COLS-1).
out_ready  input  1  downstream ready.
busy  output  1  high in DRAIN; array controller must not fire.
ovr_err  output  1  sticky overrun flag.
clr_err  input  1  clears ovr_err.

Behaviour:
- Reset (rstn=0 at a clk edge): state=COLLECT; all capture flags=0; drain index=0; out_valid=0; out_last=0; out_idx=0; out_data=0; busy=0; ovr_err=0. Bank contents don't care. Reset mid-drain abandons the frame with no partial completion.
- State COLLECT:
  - For each k with in_rvalid[k]=1 and flag[k]=0: bank[k] <= in_r[k]; flag[k] <= 1.
  - in_rvalid[k]=1 with flag[k]=1 (duplicate): bank unchanged; ovr_err <= 1.
  - Multiple PEs may be valid in the same cycle; all are captured.
  - Transition to DRAIN at the edge where every flag is set, counting captures made in that same cycle.
- State DRAIN:
  - out_valid=1; out_data=bank[idx]; out_idx=idx; out_last=(idx==ROWS*COLS-1); busy=1.
  - On out_valid & out_ready: idx <= idx+1.
  - On the final element (out_last & out_ready): state <= COLLECT; idx <= 0; all flags <= 0.
  - out_ready low holds out_data, out_idx and out_last stable. Payload must not change while valid & !ready.
  - Any in_rvalid[k]=1 in DRAIN is dropped and sets ovr_err. This includes the cycle of the final handshake.
- Latency: the last capture at edge t gives out_valid=1 after edge t, so the first element is on the stream during cycle t+1. With out_ready held high, the frame takes ROWS*COLS cycles and out_valid drops after the last handshake edge.
- Outputs are registered or decoded from state and registers only. No combinational path from in_rvalid or out_ready to any output.
- ovr_err: set has priority over clr_err when both occur in the same cycle; otherwise clr_err clears it.
- Index arithmetic is unsigned, IDXW bits. No wrap occurs because the state leaves DRAIN at ROWS*COLS-1.

Decomposition:
- Shared package (systola_pkg): drain_state_t enum {COLLECT, DRAIN}; the NPE = ROWS*COLS and IDXW derivation helpers; shared OUTWIDTH default.
- One sub-module is natural: pe_result_bank, holding the per-PE capture register, its flag, and the duplicate detect. It is instantiated ROWS*COLS times in a generate loop. The FSM and the read mux stay in the top.

Test Plan:
- Reset: rstn=0 mid-DRAIN with ROWS=COLS=2 → next cycle out_valid=0, busy=0, flags clear. A fresh set of 4 valids then drains normally.
- Diagonal wavefront, 2x2: valid idx0 at cycle 1; idx1 and idx2 at cycle 2; idx3 at cycle 3, with results 10,20,30,40 → out_valid rises cycle 4. Stream is (0,10),(1,20),(2,30),(3,40) over cycles 4-7; out_last only with idx3; busy is 0 from cycle 8.
- Backpressure: out_ready=0 for 3 cycles on idx1 → out_data=20 and out_idx=1 held stable. Total drain stretches to 7 cycles with no loss or duplication.
- Duplicate valid: idx0 valid twice before frame completion (values 5 then 9) → drained value is 5 and ovr_err=1. clr_err pulse then clears ovr_err to 0.
- Overrun during drain: in_rvalid[2]=1 on the final handshake cycle → dropped, ovr_err=1, next frame's flags all 0.
- Default 8x8, all 64 valids in one cycle with values k*3 → 64 elements in order, last=189 with out_last=1, out_ready held high.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and sizing helpers for the systolic array result path.
package systola_pkg;

  typedef enum logic [0:0] {
    StCollect,
    StDrain
  } drain_state_t;

  localparam int unsigned DefOutWidth = 32;

  function automatic int unsigned npe(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  // At least one bit so a 1x1 array still has a legal index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_result_drain_if.sv
// Result stream from the drain stage toward the output buffer / host.
interface pe_result_drain_if #(
  parameter int unsigned OUTWIDTH = 32,
  parameter int unsigned IDXW     = 6
);
  logic [OUTWIDTH-1:0] out_data;
  logic [IDXW-1:0]     out_idx;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pe_result_bank.sv
// One PE's result slot: capture register, captured flag and overrun detect.
module pe_result_bank
  import systola_pkg::*;
#(
  parameter int unsigned OUTWIDTH = DefOutWidth
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                collect,
  input  logic                clear,
  input  logic [OUTWIDTH-1:0] in_r,
  input  logic                in_rvalid,
  output logic [OUTWIDTH-1:0] result,
  output logic                filled,
  output logic                overrun
);

  logic                flag_q, flag_d;
  logic                capture;
  logic [OUTWIDTH-1:0] result_q;

  always_comb begin
    capture = collect & in_rvalid & ~flag_q;
    // A pulse is lost if the slot is already full or the frame is draining.
    overrun = in_rvalid & (flag_q | ~collect);
    filled  = flag_q | capture;
    flag_d  = flag_q;
    if (clear) begin
      flag_d = 1'b0;
    end else if (capture) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      result_q <= in_r;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/pe_result_drain.sv
// Collects one result per PE, then streams the frame out in row-major index order.
module pe_result_drain
  import systola_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned OUTWIDTH = DefOutWidth,
  parameter int unsigned IDXW     = idx_width(npe(ROWS, COLS))
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [OUTWIDTH-1:0] in_r      [ROWS*COLS],
  input  logic                in_rvalid [ROWS*COLS],
  pe_result_drain_if.master   out,
  output logic                busy,
  output logic                ovr_err,
  input  logic                clr_err
);

  localparam int unsigned    NPE     = npe(ROWS, COLS);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NPE - 1);

  drain_state_t        state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                ovr_q, ovr_d;
  logic                collect, drain, last, clear;
  logic [NPE-1:0]      filled_vec;
  logic [NPE-1:0]      overrun_vec;
  logic [OUTWIDTH-1:0] bank_data [NPE];

  for (genvar k = 0; k < NPE; k++) begin : g_bank
    pe_result_bank #(
      .OUTWIDTH(OUTWIDTH)
    ) u_bank (
      .clk      (clk),
      .rstn     (rstn),
      .collect  (collect),
      .clear    (clear),
      .in_r     (in_r[k]),
      .in_rvalid(in_rvalid[k]),
      .result   (bank_data[k]),
      .filled   (filled_vec[k]),
      .overrun  (overrun_vec[k])
    );
  end

  always_comb begin
    collect = (state_q == StCollect);
    drain   = (state_q == StDrain);
    last    = drain & (idx_q == LastIdx);
    clear   = last & out.out_ready;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StCollect: begin
        // filled_vec already counts captures landing on this edge.
        if (&filled_vec) state_d = StDrain;
      end
      StDrain: begin
        if (out.out_ready) begin
          if (last) begin
            state_d = StCollect;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StCollect;
    endcase

    ovr_d = ovr_q;
    if (|overrun_vec) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StCollect;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decode registered state only, so the payload cannot move under a stall.
  always_comb begin
    out.out_valid = drain;
    out.out_idx   = idx_q;
    out.out_last  = last;
    out.out_data  = drain ? bank_data[idx_q] : '0;
    busy          = drain;
    ovr_err       = ovr_q;
  end

endmodule
